// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall controller for the 5-stage pipeline.
// Optional retired-result bypass (select 11) is enabled by defining FWD_RETIRE_BYPASS_EN.
module fwd_hazard_unit #(
  parameter int XLEN_IDX = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [XLEN_IDX-1:0] id_rs1,
  input  logic [XLEN_IDX-1:0] id_rs2,
  input  logic [XLEN_IDX-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_is_load,
  input  logic                flush,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                stall,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef struct packed {
    logic                valid;
    logic [XLEN_IDX-1:0] rd;
    logic                load;
  } entry_t;

  typedef enum logic {RUN, STALL} state_t;

  entry_t ex_q, mem_q, wb_q, ret_q;
  entry_t id_entry;
  state_t state, state_next;
  logic   hazard;
  logic   unused_bits;

  // Nearest in-flight producer wins; the current EX/MEM/WB occupants sit one
  // stage further along by the time the consumer reaches EX.
  function automatic logic [1:0] pick_sel(input logic [XLEN_IDX-1:0] rs,
                                          input entry_t ex_e,
                                          input entry_t mem_e,
                                          input entry_t wb_e);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (ex_e.valid && ex_e.rd == rs)
        sel = 2'b01;
      else if (mem_e.valid && mem_e.rd == rs)
        sel = 2'b10;
`ifdef FWD_RETIRE_BYPASS_EN
      else if (wb_e.valid && wb_e.rd == rs)
        sel = 2'b11;
`else
      else if (wb_e.valid && wb_e.rd == rs)
        sel = 2'b00;
`endif
    end
    return sel;
  endfunction

  assign id_entry.valid = id_valid & id_reg_write & (id_rd != '0);
  assign id_entry.rd    = id_rd;
  assign id_entry.load  = id_is_load;

  assign hazard = id_valid & ex_q.valid & ex_q.load &
                  (((id_rs1 != '0) & (ex_q.rd == id_rs1)) |
                   ((id_rs2 != '0) & (ex_q.rd == id_rs2)));

  // Load flags past EX and the RET entry are tracked for visibility only.
  assign unused_bits = ^{ret_q, mem_q.load, wb_q.load};

  // Only a RUN-state hazard stalls, so a load-use costs exactly one bubble.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      RUN: begin
        if (hazard && !flush) begin
          stall      = 1'b1;
          state_next = STALL;
        end
      end
      STALL:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      ret_q     <= '0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      ret_q <= wb_q;
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (stall || flush) begin
        ex_q      <= '0;
        fwd_a_sel <= 2'b00;
        fwd_b_sel <= 2'b00;
      end else begin
        ex_q      <= id_entry;
        fwd_a_sel <= pick_sel(id_rs1, ex_q, mem_q, wb_q);
        fwd_b_sel <= pick_sel(id_rs2, ex_q, mem_q, wb_q);
      end
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
